// File: rtl/add_pipe_md_pkg.sv
// Shared helpers for the pipelined add/subtract unit: segment geometry,
// stage-index constants and the registered result-flag struct.
package add_pipe_md_pkg;

  localparam int STG_FIRST = 0;

  typedef struct packed {
    logic cout;
    logic ovf;
  } add_flags_t;

  // Nominal segment width; the last segment absorbs the remainder.
  function automatic int seg_w(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic int seg_lo(input int width, input int stages, input int k);
    return k * seg_w(width, stages);
  endfunction

  function automatic int seg_hi(input int width, input int stages, input int k);
    return (k == stages - 1) ? width - 1 : (k + 1) * seg_w(width, stages) - 1;
  endfunction

endpackage

// File: rtl/add_pipe_md_seg.sv
// Combinational carry segment. c_msb is the carry into the segment MSB,
// recovered from the sum bit so no separate narrower adder is needed.
module add_seg_md #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  assign c_msb   = s[W-1] ^ a[W-1] ^ b[W-1];

endmodule

// File: rtl/add_pipe_md.sv
// Pipelined add/subtract unit. Stage k resolves carry segment k; operand bits
// above the segment ride along in skew registers, finished result bits below it
// ride along in de-skew registers. The whole pipe freezes when the output stalls.
module add_pipe_md
  import add_pipe_md_pkg::*;
#(
  parameter int WIDTH  = 23,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] beff;
  logic             c0;
  logic             stall;
  logic             en;

  assign beff     = sub ? ~B : B;
  assign c0       = cin ^ sub;
  assign stall    = out_valid & ~out_ready;
  assign en       = ~stall;
  assign in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int LO = seg_lo(WIDTH, STAGES, k);
    localparam int HI = seg_hi(WIDTH, STAGES, k);
    localparam int SW = HI - LO + 1;

    logic [SW-1:0] sa, sb, ss;
    logic          sci, sco, smsb;
    logic [HI:0]   s_d, s_q;
    logic          v_d, v_q;

    if (k == STG_FIRST) begin : g_src
      assign sa  = A[HI:LO];
      assign sb  = beff[HI:LO];
      assign sci = c0;
      assign s_d = ss;
      assign v_d = in_valid;
    end else begin : g_src
      assign sa  = stg[k-1].g_skew.a_q[HI:LO];
      assign sb  = stg[k-1].g_skew.b_q[HI:LO];
      assign sci = stg[k-1].g_skew.co_q;
      assign s_d = {ss, stg[k-1].s_q};
      assign v_d = stg[k-1].v_q;
    end

    add_seg_md #(.W(SW)) u_seg (
      .a    (sa),
      .b    (sb),
      .ci   (sci),
      .s    (ss),
      .co   (sco),
      .c_msb(smsb)
    );

    // Stage valid bit and accumulated low result bits, frozen while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        s_q <= '0;
      end else if (en) begin
        v_q <= v_d;
        s_q <= s_d;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [WIDTH-1:HI+1] a_d, b_d, a_q, b_q;
      logic                co_q;

      if (k == STG_FIRST) begin : g_in
        assign a_d = A[WIDTH-1:HI+1];
        assign b_d = beff[WIDTH-1:HI+1];
      end else begin : g_in
        assign a_d = stg[k-1].g_skew.a_q[WIDTH-1:HI+1];
        assign b_d = stg[k-1].g_skew.b_q[WIDTH-1:HI+1];
      end

      // Carry into the next segment plus the not-yet-added operand bits.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q  <= '0;
          b_q  <= '0;
          co_q <= 1'b0;
        end else if (en) begin
          a_q  <= a_d;
          b_q  <= b_d;
          co_q <= sco;
        end
      end
    end else begin : g_flg
      add_flags_t flg_q;

      // Final carry-out and signed overflow from the top segment.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          flg_q <= '0;
        end else if (en) begin
          flg_q <= '{cout: sco, ovf: smsb ^ sco};
        end
      end
    end
  end

  assign out_valid = stg[STAGES-1].v_q;
  assign out       = stg[STAGES-1].s_q;
  assign cout      = stg[STAGES-1].g_flg.flg_q.cout;
  assign ovf       = stg[STAGES-1].g_flg.flg_q.ovf;

endmodule

// File: tb/tb_add_pipe_md.sv
// Bench for add_pipe_md: directed cases on a STAGES=3 instance, then random
// traffic with random back-pressure on STAGES=1, 3 and 23 instances.
module tb_add_pipe_md;

  localparam int W = 23;
  localparam int NB = 3334;

  logic          clk;
  logic          rst_n;
  logic          in_valid [3];
  logic          in_ready [3];
  logic [W-1:0]  a_s [3];
  logic [W-1:0]  b_s [3];
  logic          sub_s [3];
  logic          cin_s [3];
  logic          out_valid [3];
  logic          ordy_s [3];
  logic [W-1:0]  out_s [3];
  logic          cout_s [3];
  logic          ovf_s [3];

  logic [W+1:0]  sbq [3][$];
  logic          rnd_go;
  logic          done [3];
  int            n_chk;
  int            n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {ovf, cout, out}; overflow from operand/result signs.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s, input logic c);
    logic [W-1:0] be;
    logic [W:0]   sum;
    logic         v;
    be  = s ? ~b : b;
    sum = {1'b0, a} + {1'b0, be} + (W+1)'(c ^ s);
    v   = (a[W-1] == be[W-1]) && (sum[W-1] != a[W-1]);
    return {v, sum[W], sum[W-1:0]};
  endfunction

  // One cycle on DUT d: drive at negedge, then score consume and accept.
  task automatic cyc(input int d, input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic s, input logic c, input logic ordy, input logic [W+1:0] exp);
    @(negedge clk);
    in_valid[d] = iv;
    a_s[d]      = a;
    b_s[d]      = b;
    sub_s[d]    = s;
    cin_s[d]    = c;
    ordy_s[d]   = ordy;
    #1;
    if (out_valid[d] && ordy_s[d]) begin
      if (sbq[d].size() == 0)
        chk($sformatf("unexp%0d", d), 32'(out_valid[d]), 32'd0);
      else
        chk($sformatf("sb%0d", d), 32'({ovf_s[d], cout_s[d], out_s[d]}), 32'(sbq[d].pop_front()));
    end
    if (iv && in_ready[d]) sbq[d].push_back(exp);
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (sbq[d].size() != 0 && n < 200) begin
      cyc(d, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0);
      n++;
    end
    chk($sformatf("drain%0d", d), 32'(sbq[d].size()), 32'd0);
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int ST = (gi == 0) ? 1 : ((gi == 1) ? 3 : 23);

    add_pipe_md #(.WIDTH(W), .STAGES(ST)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[gi]),
      .in_ready (in_ready[gi]),
      .A        (a_s[gi]),
      .B        (b_s[gi]),
      .sub      (sub_s[gi]),
      .cin      (cin_s[gi]),
      .out_valid(out_valid[gi]),
      .out_ready(ordy_s[gi]),
      .out      (out_s[gi]),
      .cout     (cout_s[gi]),
      .ovf      (ovf_s[gi])
    );

    initial begin : rnd
      int            acc;
      int            cn;
      logic [W-1:0]  ra, rb;
      logic          rs, rc, riv, rrdy;
      logic [W-1:0]  corner [4];
      corner[0] = '0;
      corner[1] = 23'h7FFFFF;
      corner[2] = 23'h400000;
      corner[3] = 23'h3FFFFF;
      acc = 0;
      cn  = 0;
      wait (rnd_go);
      while (acc < NB && cn < 20000) begin
        ra   = W'($urandom);
        rb   = W'($urandom);
        if ($urandom_range(7) == 0) ra = corner[$urandom_range(3)];
        if ($urandom_range(7) == 0) rb = corner[$urandom_range(3)];
        rs   = 1'($urandom_range(1));
        rc   = 1'($urandom_range(1));
        riv  = ($urandom_range(3) != 0);
        rrdy = ($urandom_range(9) < 7);
        cyc(gi, riv, ra, rb, rs, rc, rrdy, model(ra, rb, rs, rc));
        if (riv && in_ready[gi]) acc++;
        cn++;
      end
      chk($sformatf("rnd_beats%0d", gi), 32'(acc), 32'(NB));
      drain(gi);
      done[gi] = 1'b1;
    end
  end

  initial begin : main
    int lat;
    int seen;
    int ndone;
    logic [W+1:0] held;
    logic [W+1:0] e1;
    n_chk  = 0;
    n_err  = 0;
    rnd_go = 1'b0;
    rst_n  = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0;
      a_s[d]      = '0;
      b_s[d]      = '0;
      sub_s[d]    = 1'b0;
      cin_s[d]    = 1'b0;
      ordy_s[d]   = 1'b1;
      done[d]     = 1'b0;
    end

    // Reset with traffic present.
    in_valid[1] = 1'b1;
    a_s[1]      = 23'h123456;
    b_s[1]      = 23'h654321;
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++)
      chk($sformatf("rst_out%0d", d), 32'({out_valid[d], ovf_s[d], cout_s[d], out_s[d]}), 32'd0);
    @(negedge clk);
    rst_n       = 1'b1;
    in_valid[1] = 1'b0;
    #1;
    chk("rst_rdy", 32'(in_ready[1]), 32'd1);

    // Carry across both segment boundaries, with latency measurement.
    cyc(1, 1'b1, 23'h7FFFFF, 23'h000001, 1'b0, 1'b0, 1'b1, {1'b0, 1'b1, 23'h000000});
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      cyc(1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0);
      if (out_valid[1] && lat == 0) lat = i;
    end
    chk("t2_lat", 32'(lat), 32'd3);

    // Subtract with/without borrow-in, and signed overflow both ways.
    cyc(1, 1'b1, 23'h000005, 23'h000007, 1'b1, 1'b0, 1'b1, {1'b0, 1'b0, 23'h7FFFFE});
    cyc(1, 1'b1, 23'h000005, 23'h000007, 1'b1, 1'b1, 1'b1, {1'b0, 1'b0, 23'h7FFFFD});
    cyc(1, 1'b1, 23'h3FFFFF, 23'h000001, 1'b0, 1'b0, 1'b1, {1'b1, 1'b0, 23'h400000});
    cyc(1, 1'b1, 23'h400000, 23'h000001, 1'b1, 1'b0, 1'b1, {1'b1, 1'b1, 23'h3FFFFF});
    drain(1);

    // Three back-to-back beats, two stall cycles when the first arrives.
    e1 = model(23'h0ABCDE, 23'h012345, 1'b0, 1'b1);
    cyc(1, 1'b1, 23'h0ABCDE, 23'h012345, 1'b0, 1'b1, 1'b1, e1);
    cyc(1, 1'b1, 23'h7F0000, 23'h00FFFF, 1'b1, 1'b0, 1'b1, model(23'h7F0000, 23'h00FFFF, 1'b1, 1'b0));
    cyc(1, 1'b1, 23'h2AAAAA, 23'h555555, 1'b0, 1'b1, 1'b1, model(23'h2AAAAA, 23'h555555, 1'b0, 1'b1));
    cyc(1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    chk("t5_v", 32'(out_valid[1]), 32'd1);
    chk("t5_rdy0", 32'(in_ready[1]), 32'd0);
    held = {ovf_s[1], cout_s[1], out_s[1]};
    chk("t5_head", 32'(held), 32'(e1));
    cyc(1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    chk("t5_rdy1", 32'(in_ready[1]), 32'd0);
    chk("t5_hold", 32'({ovf_s[1], cout_s[1], out_s[1]}), 32'(held));
    chk("t5_depth", 32'(sbq[1].size()), 32'd3);
    drain(1);

    // Reset pulse with two beats in flight.
    cyc(1, 1'b1, 23'h001111, 23'h002222, 1'b0, 1'b0, 1'b1, model(23'h001111, 23'h002222, 1'b0, 1'b0));
    cyc(1, 1'b1, 23'h003333, 23'h004444, 1'b1, 1'b0, 1'b1, model(23'h003333, 23'h004444, 1'b1, 1'b0));
    @(negedge clk);
    rst_n       = 1'b0;
    in_valid[1] = 1'b0;
    #1;
    chk("t6_rst", 32'({out_valid[1], ovf_s[1], cout_s[1], out_s[1]}), 32'd0);
    sbq[1].delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    repeat (8) begin
      cyc(1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0);
      if (out_valid[1]) seen++;
    end
    chk("t6_quiet", 32'(seen), 32'd0);

    // Random traffic on all three depths.
    rnd_go = 1'b1;
    ndone  = 0;
    for (int i = 0; i < 60000 && ndone < 3; i++) begin
      @(negedge clk);
      ndone = 0;
      for (int d = 0; d < 3; d++) if (done[d]) ndone++;
    end
    chk("rnd_done", 32'(ndone), 32'd3);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
